fre_meas_ctrl: RTL and testbench

FRE_MEAS_CTRL -- requirements
Module: fre_meas_ctrl

---
 rtl/fre_meas_ctrl.sv | 158 +++++++++++++++
 tb/tb_fre_meas_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fre_meas_ctrl.sv
// Measurement-run controller: drops the partial first gate, accumulates 2^AVG_LOG2
// gate counts from the frequency-measure block, and hands the result over with valid/ready.
//
// state   | meaning
// IDLE    | waiting for start; sums/gate_cnt keep their last values
// DISCARD | run started, waiting to drop the first (partial) gate
// ACC     | accumulating M/N on every gate end
// OUT     | result presented; held until valid & ready
module fre_meas_ctrl #(
    parameter int          AVG_LOG2 = 2,
    parameter logic [31:0] TIMEOUT  = 32'd200_000_000
) (
    input  logic        clk_100M,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] M_in,
    input  logic [31:0] N_in,
    input  logic        irq_in,
    output logic [39:0] M_sum,
    output logic [39:0] N_sum,
    output logic [8:0]  gate_cnt,
    output logic        valid,
    input  logic        ready,
    output logic        busy,
    output logic        timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DISCARD = 2'd1,
        ACC     = 2'd2,
        OUT     = 2'd3
    } state_t;

    localparam logic [8:0]  C_FULL   = 9'd1 << AVG_LOG2;
    localparam logic [31:0] C_TO_END = TIMEOUT - 32'd1;

    state_t      r_state;
    state_t      w_next;
    logic        r_irq_d;
    logic [31:0] r_to_cnt;
    logic [39:0] r_m_sum;
    logic [39:0] r_n_sum;
    logic [8:0]  r_gate_cnt;
    logic        r_timeout;

    logic        w_gate_end;
    logic        w_to_expired;
    logic        w_clear;
    logic        w_acc;
    logic        w_to_hit;
    logic        w_running;

    assign w_gate_end   = r_irq_d & ~irq_in;
    assign w_to_expired = (r_to_cnt == C_TO_END);
    assign w_running    = (r_state == DISCARD) || (r_state == ACC);

    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_irq_d <= 1'b0;
        end else begin
            r_state <= w_next;
            r_irq_d <= irq_in;
        end
    end

    // Gate end takes precedence over an expiring timeout in the same cycle.
    always_comb begin
        w_next   = r_state;
        w_clear  = 1'b0;
        w_acc    = 1'b0;
        w_to_hit = 1'b0;
        if (abort) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        w_next  = DISCARD;
                        w_clear = 1'b1;
                    end
                end
                DISCARD: begin
                    if (w_gate_end) begin
                        w_next = ACC;
                    end else if (w_to_expired) begin
                        w_next   = OUT;
                        w_to_hit = 1'b1;
                    end
                end
                ACC: begin
                    if (w_gate_end) begin
                        w_acc = 1'b1;
                        if (r_gate_cnt + 9'd1 == C_FULL) begin
                            w_next = OUT;
                        end
                    end else if (w_to_expired) begin
                        w_next   = OUT;
                        w_to_hit = 1'b1;
                    end
                end
                OUT: begin
                    if (ready) begin
                        w_next = IDLE;
                    end
                end
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= 32'd0;
        end else if (w_clear || w_gate_end) begin
            r_to_cnt <= 32'd0;
        end else if (w_running) begin
            r_to_cnt <= r_to_cnt + 32'd1;
        end
    end

    // Abort leaves the partial sums in place; valid is what marks them unusable.
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            r_m_sum    <= 40'd0;
            r_n_sum    <= 40'd0;
            r_gate_cnt <= 9'd0;
        end else if (w_clear) begin
            r_m_sum    <= 40'd0;
            r_n_sum    <= 40'd0;
            r_gate_cnt <= 9'd0;
        end else if (w_acc) begin
            r_m_sum    <= r_m_sum + {8'd0, M_in};
            r_n_sum    <= r_n_sum + {8'd0, N_in};
            r_gate_cnt <= r_gate_cnt + 9'd1;
        end
    end

    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            r_timeout <= 1'b0;
        end else if (abort || w_clear) begin
            r_timeout <= 1'b0;
        end else if (w_to_hit) begin
            r_timeout <= 1'b1;
        end
    end

    assign M_sum    = r_m_sum;
    assign N_sum    = r_n_sum;
    assign gate_cnt = r_gate_cnt;
    assign timeout  = r_timeout;
    assign valid    = (r_state == OUT);
    assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_fre_meas_ctrl.sv
// Directed bench for fre_meas_ctrl (AVG_LOG2=2, TIMEOUT=1000) with a result scoreboard.
module tb_fre_meas_ctrl;

    logic        clk_100M = 1'b0;
    logic        rst_n    = 1'b0;
    logic        start    = 1'b0;
    logic        abort    = 1'b0;
    logic [31:0] M_in     = 32'd0;
    logic [31:0] N_in     = 32'd0;
    logic        irq_in   = 1'b0;
    logic        ready    = 1'b0;
    logic [39:0] M_sum;
    logic [39:0] N_sum;
    logic [8:0]  gate_cnt;
    logic        valid;
    logic        busy;
    logic        timeout;

    fre_meas_ctrl #(.AVG_LOG2(2), .TIMEOUT(32'd1000)) dut (
        .clk_100M (clk_100M),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .M_in     (M_in),
        .N_in     (N_in),
        .irq_in   (irq_in),
        .M_sum    (M_sum),
        .N_sum    (N_sum),
        .gate_cnt (gate_cnt),
        .valid    (valid),
        .ready    (ready),
        .busy     (busy),
        .timeout  (timeout)
    );

    always #5 clk_100M = ~clk_100M;

    typedef struct {
        logic [39:0] m;
        logic [39:0] n;
        logic [8:0]  cnt;
        logic        to;
    } res_t;

    res_t sb[$];
    res_t last;
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk_100M);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One gate: irq_in high for hi cycles, then the falling edge; returns just after
    // the clock edge that sees the gate end.
    task automatic gate(input logic [31:0] m, input logic [31:0] n, input int hi,
                        input logic ab = 1'b0);
        M_in   = m;
        N_in   = n;
        irq_in = 1'b1;
        step(hi);
        irq_in = 1'b0;
        abort  = ab;
        step();
        abort  = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic expect_result(input string tag, input int budget);
        int k;
        k = 0;
        while (valid !== 1'b1 && k < budget) begin
            step();
            k++;
        end
        chk({tag, "_valid"}, valid, 1);
        last = sb.pop_front();
        chk({tag, "_M_sum"}, M_sum, last.m);
        chk({tag, "_N_sum"}, N_sum, last.n);
        chk({tag, "_gate_cnt"}, gate_cnt, last.cnt);
        chk({tag, "_timeout"}, timeout, last.to);
        chk({tag, "_busy"}, busy, 1);
    endtask

    task automatic handshake(input string tag);
        ready = 1'b1;
        step();
        ready = 1'b0;
        chk({tag, "_hs_valid"}, valid, 0);
        chk({tag, "_hs_busy"}, busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic seen;

        // reset state
        step(2);
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_M_sum", M_sum, 0);
        chk("rst_N_sum", N_sum, 0);
        chk("rst_gate_cnt", gate_cnt, 0);
        rst_n = 1'b1;
        step();

        // full 4-gate run, first gate dropped, exact latency
        sb.push_back('{40'd400_000_000, 40'd4000, 9'd4, 1'b0});
        do_start();
        chk("A_busy", busy, 1);
        gate(32'd100_000_000, 32'd1000, 5);
        chk("A_discard_cnt", gate_cnt, 0);
        chk("A_discard_M", M_sum, 0);
        for (int i = 0; i < 3; i++) gate(32'd100_000_000, 32'd1000, 5);
        chk("A_cnt3", gate_cnt, 3);
        chk("A_no_valid_early", valid, 0);
        gate(32'd100_000_000, 32'd1000, 5);
        chk("A_latency", valid, 1);
        expect_result("A", 0);

        // hold with ready low while irq toggles and start is pulsed
        for (int i = 0; i < 50; i++) begin
            irq_in = (i % 3 != 2);
            M_in   = $urandom;
            N_in   = $urandom;
            start  = (i == 10);
            step();
        end
        start  = 1'b0;
        irq_in = 1'b0;
        chk("hold_valid", valid, 1);
        chk("hold_M_sum", M_sum, last.m);
        chk("hold_N_sum", N_sum, last.n);
        chk("hold_gate_cnt", gate_cnt, last.cnt);
        chk("hold_timeout", timeout, last.to);
        start = 1'b1;
        handshake("hold");
        start = 1'b0;
        step(3);
        chk("hold_start_ignored", busy, 0);

        // timeout in ACC after one accumulated gate
        sb.push_back('{40'd7, 40'd3, 9'd1, 1'b1});
        do_start();
        gate(32'd50, 32'd60, 4);
        gate(32'd7, 32'd3, 4);
        step(999);
        chk("B_no_valid_999", valid, 0);
        step();
        chk("B_latency", valid, 1);
        expect_result("B", 0);
        handshake("B");

        // timeout while still in DISCARD
        sb.push_back('{40'd0, 40'd0, 9'd0, 1'b1});
        do_start();
        step(999);
        chk("C_no_valid_999", valid, 0);
        step();
        expect_result("C", 0);
        handshake("C");

        // abort coincident with a gate end in ACC
        do_start();
        gate(32'd5, 32'd6, 3);
        gate(32'd100, 32'd200, 3);
        gate(32'd100, 32'd200, 3);
        gate(32'd100, 32'd200, 3, 1'b1);
        chk("D_busy", busy, 0);
        chk("D_valid", valid, 0);
        chk("D_timeout", timeout, 0);
        chk("D_M_kept", M_sum, 200);
        chk("D_N_kept", N_sum, 400);
        chk("D_cnt_kept", gate_cnt, 2);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            gate(32'd1, 32'd1, 2);
            if (valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        chk("D_no_valid_after", seen, 0);

        // clean run after abort; start and ready pulsed mid-ACC must be ignored
        sb.push_back('{40'd10_000, 40'd10, 9'd4, 1'b0});
        do_start();
        gate(32'd9, 32'd9, 2);
        for (int i = 1; i <= 4; i++) begin
            gate(32'(i * 1000), 32'(i), 3);
            if (i == 2) begin
                ready = 1'b1;
                do_start();
                ready = 1'b0;
                chk("E_start_in_acc_cnt", gate_cnt, 2);
                chk("E_start_in_acc_M", M_sum, 3000);
            end
        end
        chk("E_latency", valid, 1);
        expect_result("E", 0);
        handshake("E");

        // asynchronous reset mid-ACC
        do_start();
        gate(32'd1, 32'd1, 2);
        gate(32'd3, 32'd4, 2);
        gate(32'd3, 32'd4, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("R_busy", busy, 0);
        chk("R_valid", valid, 0);
        chk("R_M_sum", M_sum, 0);
        chk("R_N_sum", N_sum, 0);
        chk("R_gate_cnt", gate_cnt, 0);
        chk("R_timeout", timeout, 0);
        step(2);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            gate(32'd2, 32'd2, 2);
            if (valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        chk("R_no_result", seen, 0);

        // every gate end lands exactly on timeout count 999; max-value samples
        sb.push_back('{40'h3_FFFF_FFFC, 40'h3_FFFF_FFFC, 9'd4, 1'b0});
        do_start();
        gate(32'd0, 32'd0, 3);
        for (int i = 0; i < 3; i++) begin
            gate(32'hFFFF_FFFF, 32'hFFFF_FFFF, 999);
            chk("F_no_to_valid", valid, 0);
            chk("F_no_to_flag", timeout, 0);
        end
        gate(32'hFFFF_FFFF, 32'hFFFF_FFFF, 999);
        chk("F_latency", valid, 1);
        expect_result("F", 0);
        handshake("F");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
